// File: rtl/time_counter_24h_pkg.sv
// Shared clock-field constants, the time-of-day record and the load range check,
// used by the counter core, the 24h->12h converter and the display drivers.
package time_counter_24h_pkg;

    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int SEC_W    = 6;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
    } hms_t;

    // A loaded time is accepted only if every field is within its clock range.
    function automatic logic time_in_range(hms_t t);
        return (int'(t.hour) <= HOUR_MAX) &&
               (int'(t.minute) <= MIN_MAX) &&
               (int'(t.second) <= SEC_MAX);
    endfunction

endpackage

// File: rtl/time_counter_24h_if.sv
// Control and time-of-day bus of the timekeeping core; master drives commands,
// slave (the counter) returns the current time and event pulses.
interface time_counter_24h_if;
    import time_counter_24h_pkg::*;

    logic              tick;
    logic              run;
    logic              load;
    logic [HOUR_W-1:0] load_hour;
    logic [MIN_W-1:0]  load_min;
    logic [SEC_W-1:0]  load_sec;
    logic              inc_hour;
    logic              inc_min;
    logic [HOUR_W-1:0] hour24;
    logic [MIN_W-1:0]  minute;
    logic [SEC_W-1:0]  second;
    logic              min_tick;
    logic              day_tick;
    logic              load_err;

    modport master (
        output tick, run, load, load_hour, load_min, load_sec, inc_hour, inc_min,
        input  hour24, minute, second, min_tick, day_tick, load_err
    );

    modport slave (
        input  tick, run, load, load_hour, load_min, load_sec, inc_hour, inc_min,
        output hour24, minute, second, min_tick, day_tick, load_err
    );

endinterface

// File: rtl/time_counter_24h_mod_counter.sv
// Modulo-N counter with load, clear, carry-free increment and counting enable;
// wrap flags the counting step from MODULUS-1 back to 0 so stages can be chained.
module mod_counter #(
    parameter int MODULUS   = 60,
    parameter int WIDTH     = 6,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc_nocarry,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic             at_last;
    logic [WIDTH-1:0] count_next;

    assign at_last    = (count == LAST);
    assign count_next = at_last ? '0 : count + WIDTH'(1);

    // Only a plain counting step carries; load, clear and adjust never do.
    assign wrap = en & ~load & ~clr & ~inc_nocarry & at_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= WIDTH'(RESET_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (clr) begin
            count <= '0;
        end else if (inc_nocarry || en) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/time_counter_24h.sv
// Timekeeping core: prescaler -> seconds -> minutes -> hours (24 h), with run/stop,
// range-checked direct load, carry-free hour/minute adjust and registered event pulses.
module time_counter_24h
    import time_counter_24h_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1,
    parameter int RESET_HOUR    = 0,
    parameter int RESET_MIN     = 0
) (
    input  logic                clk,
    input  logic                rst,
    time_counter_24h_if.slave   bus
);

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    hms_t              load_req;
    logic              load_valid;
    logic              load_ok;
    logic              load_bad;
    logic              inc_hour_ok;
    logic              inc_min_ok;
    logic              tick_ok;

    logic [PRE_W-1:0]  pre_count_unused;
    logic              pre_wrap;
    logic              sec_wrap;
    logic              min_wrap;
    logic              hour_wrap;

    logic [HOUR_W-1:0] hour_q;
    logic [MIN_W-1:0]  min_q;
    logic [SEC_W-1:0]  sec_q;
    logic              min_tick_q;
    logic              day_tick_q;
    logic              load_err_q;

    assign load_req   = '{hour: bus.load_hour, minute: bus.load_min, second: bus.load_sec};
    assign load_valid = time_in_range(load_req);

    // Priority load > adjust > tick; a rejected load still blocks everything below it.
    assign load_ok     = bus.load & load_valid;
    assign load_bad    = bus.load & ~load_valid;
    assign inc_hour_ok = bus.inc_hour & ~bus.load;
    assign inc_min_ok  = bus.inc_min & ~bus.load;
    assign tick_ok     = bus.tick & bus.run & ~bus.load & ~bus.inc_hour & ~bus.inc_min;

    mod_counter #(.MODULUS(TICKS_PER_SEC), .WIDTH(PRE_W), .RESET_VAL(0)) u_pre (
        .clk(clk), .rst(rst), .en(tick_ok), .load(load_ok), .load_val('0),
        .inc_nocarry(1'b0), .clr(inc_min_ok), .count(pre_count_unused), .wrap(pre_wrap)
    );

    mod_counter #(.MODULUS(SEC_MAX + 1), .WIDTH(SEC_W), .RESET_VAL(0)) u_sec (
        .clk(clk), .rst(rst), .en(pre_wrap), .load(load_ok), .load_val(bus.load_sec),
        .inc_nocarry(1'b0), .clr(inc_min_ok), .count(sec_q), .wrap(sec_wrap)
    );

    mod_counter #(.MODULUS(MIN_MAX + 1), .WIDTH(MIN_W), .RESET_VAL(RESET_MIN)) u_min (
        .clk(clk), .rst(rst), .en(sec_wrap), .load(load_ok), .load_val(bus.load_min),
        .inc_nocarry(inc_min_ok), .clr(1'b0), .count(min_q), .wrap(min_wrap)
    );

    mod_counter #(.MODULUS(HOUR_MAX + 1), .WIDTH(HOUR_W), .RESET_VAL(RESET_HOUR)) u_hour (
        .clk(clk), .rst(rst), .en(min_wrap), .load(load_ok), .load_val(bus.load_hour),
        .inc_nocarry(inc_hour_ok), .clr(1'b0), .count(hour_q), .wrap(hour_wrap)
    );

    // hour_wrap can only assert at the end of a full 23:59:59 carry chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            min_tick_q <= sec_wrap;
            day_tick_q <= hour_wrap;
            load_err_q <= load_bad;
        end
    end

    assign bus.hour24   = hour_q;
    assign bus.minute   = min_q;
    assign bus.second   = sec_q;
    assign bus.min_tick = min_tick_q;
    assign bus.day_tick = day_tick_q;
    assign bus.load_err = load_err_q;

endmodule
